// File: rtl/golden_epoch_if.sv
// Golden-token bus: run/freeze control and golden_done in, the shared token plus
// epoch status out. The master is the epoch controller; routers and bench sit on slave.
interface golden_epoch_if #(
    parameter int PKTID_W = 4,
    parameter int COORD_W = 4,
    parameter int TIMER_W = 6
);
    logic                       enable;
    logic                       freeze;
    logic                       golden_done;
    logic [PKTID_W+COORD_W-1:0] counterGolden;
    logic                       golden_valid;
    logic                       epoch_start;
    logic [TIMER_W-1:0]         epoch_timer;

    modport master (
        input  enable, freeze, golden_done,
        output counterGolden, golden_valid, epoch_start, epoch_timer
    );

    modport slave (
        output enable, freeze, golden_done,
        input  counterGolden, golden_valid, epoch_start, epoch_timer
    );
endinterface

// File: rtl/golden_epoch_ctrl.sv
// Mesh-wide golden token sequencer: walks {pktID, srcX, srcY} as an odometer, one
// value per epoch, ending an epoch on timer expiry or, optionally, on golden_done.
module golden_epoch_ctrl #(
    parameter int PKTID_W   = 4,
    parameter int COORD_W   = 4,
    parameter int MESH_X    = 4,
    parameter int MESH_Y    = 4,
    parameter int EPOCH_LEN = 64,
    parameter int EARLY_ADV = 1
) (
    input logic            clk,
    input logic            reset,
    golden_epoch_if.master gif
);
    localparam int HALF    = COORD_W / 2;
    localparam int TIMER_W = $clog2(EPOCH_LEN);

    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(EPOCH_LEN - 1);
    localparam logic [HALF-1:0]    X_MAX     = HALF'(MESH_X - 1);
    localparam logic [HALF-1:0]    Y_MAX     = HALF'(MESH_Y - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PKTID_W-1:0]   pkt_q, pkt_d, pkt_inc;
    logic [HALF-1:0]      x_q, x_d, x_inc;
    logic [HALF-1:0]      y_q, y_d, y_inc;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 valid_q, valid_d;
    logic                 start_q, start_d;
    logic                 adv;

    // Odometer successor: pktID is the fastest digit, then srcY, then srcX.
    // Coordinates wrap at the mesh edge so out-of-mesh codes never appear.
    always_comb begin
        pkt_inc = pkt_q + PKTID_W'(1);
        y_inc   = y_q;
        x_inc   = x_q;
        if (pkt_q == '1) begin
            if (y_q == Y_MAX) begin
                y_inc = '0;
                x_inc = (x_q == X_MAX) ? '0 : x_q + HALF'(1);
            end else begin
                y_inc = y_q + HALF'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        x_d     = x_q;
        y_d     = y_q;
        timer_d = timer_q;
        start_d = 1'b0;
        adv     = (timer_q == '0) || ((EARLY_ADV != 0) && gif.golden_done);

        case (state_q)
            IDLE: begin
                timer_d = TIMER_MAX;
                if (gif.enable) begin
                    // Entry re-announces the held token rather than advancing it.
                    state_d = RUN;
                    start_d = 1'b1;
                end
            end
            RUN: begin
                if (!gif.enable) begin
                    state_d = IDLE;
                    timer_d = TIMER_MAX;
                end else if (gif.freeze) begin
                    // Freeze wins over an advance due in the same cycle.
                    state_d = HOLD;
                end else if (adv) begin
                    pkt_d   = pkt_inc;
                    x_d     = x_inc;
                    y_d     = y_inc;
                    timer_d = TIMER_MAX;
                    start_d = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            HOLD: begin
                if (!gif.enable) begin
                    state_d = IDLE;
                    timer_d = TIMER_MAX;
                end else if (!gif.freeze) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = TIMER_MAX;
            end
        endcase

        valid_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pkt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            timer_q <= TIMER_MAX;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            timer_q <= timer_d;
            valid_q <= valid_d;
            start_q <= start_d;
        end
    end

    assign gif.counterGolden = {pkt_q, COORD_W'({x_q, y_q})};
    assign gif.golden_valid  = valid_q;
    assign gif.epoch_start   = start_q;
    assign gif.epoch_timer   = timer_q;
endmodule

// File: tb/tb_golden_epoch_ctrl.sv
// Scoreboard bench: two controllers (early advance on/off) share one stimulus stream;
// expectations are queued per cycle and a negedge monitor pops and compares them.
module tb_golden_epoch_ctrl;
    typedef struct packed {
        logic       valid;
        logic       start;
        logic [2:0] timer;
        logic [3:0] tok;
    } exp_t;

    typedef struct {
        int   cyc;
        bit   col;
        exp_t a;
        exp_t b;
    } entry_t;

    typedef struct {
        int    cyc;
        bit    on_b;
        exp_t  e;
        string nm;
    } dentry_t;

    typedef struct {
        int st;
        int idx;
        int timer;
        bit valid;
        bit start;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, frz = 1'b0, done = 1'b0;

    always #5 clk = ~clk;

    golden_epoch_if #(.PKTID_W(2), .COORD_W(2), .TIMER_W(3)) ifa ();
    golden_epoch_if #(.PKTID_W(2), .COORD_W(2), .TIMER_W(3)) ifb ();

    assign ifa.enable = en;  assign ifa.freeze = frz;  assign ifa.golden_done = done;
    assign ifb.enable = en;  assign ifb.freeze = frz;  assign ifb.golden_done = done;

    golden_epoch_ctrl #(.PKTID_W(2), .COORD_W(2), .MESH_X(2), .MESH_Y(2),
                        .EPOCH_LEN(8), .EARLY_ADV(1)) dut_a (.clk(clk), .reset(rst), .gif(ifa));
    golden_epoch_ctrl #(.PKTID_W(2), .COORD_W(2), .MESH_X(2), .MESH_Y(2),
                        .EPOCH_LEN(8), .EARLY_ADV(0)) dut_b (.clk(clk), .reset(rst), .gif(ifb));

    entry_t  q[$];
    dentry_t dq[$];
    mdl_t    ma = '{0, 0, 7, 1'b0, 1'b0};
    mdl_t    mb = '{0, 0, 7, 1'b0, 1'b0};
    int      sc = 0;
    int      checks = 0, passes = 0;
    logic [15:0] seen = '0;
    int      dups = 0, npulse = 0;

    // Reference: epoch index n maps to pkt = n%4, srcY = (n/4)%2, srcX = (n/8)%2.
    function automatic exp_t to_exp(mdl_t m);
        exp_t e;
        e.valid = m.valid;
        e.start = m.start;
        e.timer = 3'(m.timer);
        e.tok   = 4'(((m.idx % 4) << 2) | (((m.idx / 8) % 2) << 1) | ((m.idx / 4) % 2));
        return e;
    endfunction

    function automatic mdl_t mnext(mdl_t m, bit ea, bit r, bit e, bit f, bit d);
        mdl_t n = m;
        if (r) return '{0, 0, 7, 1'b0, 1'b0};
        n.start = 1'b0;
        case (m.st)
            0: begin
                n.timer = 7;
                if (e) begin n.st = 1; n.start = 1'b1; end
            end
            1: begin
                if (!e) begin n.st = 0; n.timer = 7; end
                else if (f) n.st = 2;
                else if (m.timer == 0 || (ea && d)) begin
                    n.idx = (m.idx + 1) % 16; n.timer = 7; n.start = 1'b1;
                end else n.timer = m.timer - 1;
            end
            default: begin
                if (!e) begin n.st = 0; n.timer = 7; end
                else if (!f) n.st = 1;
            end
        endcase
        n.valid = (n.st != 0);
        return n;
    endfunction

    function automatic exp_t mk(bit v, bit s, int t, int tok);
        exp_t e;
        e.valid = v; e.start = s; e.timer = 3'(t); e.tok = 4'(tok);
        return e;
    endfunction

    task automatic chk(string nm, int cyc, exp_t got, exp_t want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s cyc=%0d got v=%b s=%b t=%0d tok=%h, want v=%b s=%b t=%0d tok=%h",
                      nm, cyc, got.valid, got.start, got.timer, got.tok,
                      want.valid, want.start, want.timer, want.tok);
    endtask

    task automatic chk_int(string nm, int got, int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s got %0d want %0d", nm, got, want);
    endtask

    task automatic step(bit r, bit e, bit f, bit d, bit c);
        entry_t en_t;
        @(negedge clk);
        rst = r; en = e; frz = f; done = d;
        @(posedge clk);
        ma = mnext(ma, 1'b1, r, e, f, d);
        mb = mnext(mb, 1'b0, r, e, f, d);
        sc++;
        en_t.cyc = sc; en_t.col = c; en_t.a = to_exp(ma); en_t.b = to_exp(mb);
        q.push_back(en_t);
    endtask

    task automatic run(int n, bit c);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, c);
    endtask

    // Hand-computed expectation for the step just issued.
    task automatic expect_at(string nm, bit on_b, exp_t e);
        dentry_t d;
        d.cyc = sc; d.on_b = on_b; d.e = e; d.nm = nm;
        dq.push_back(d);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            entry_t e;
            exp_t ga, gb;
            e = q.pop_front();
            ga = {ifa.golden_valid, ifa.epoch_start, ifa.epoch_timer, ifa.counterGolden};
            gb = {ifb.golden_valid, ifb.epoch_start, ifb.epoch_timer, ifb.counterGolden};
            chk("model_a", e.cyc, ga, e.a);
            chk("model_b", e.cyc, gb, e.b);
            while (dq.size() > 0 && dq[0].cyc == e.cyc) begin
                dentry_t d;
                d = dq.pop_front();
                chk(d.nm, e.cyc, d.on_b ? gb : ga, d.e);
            end
            if (e.col && ifa.epoch_start === 1'b1) begin
                if (seen[ifa.counterGolden]) dups++;
                seen[ifa.counterGolden] = 1'b1;
                npulse++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at("reset_a", 1'b0, mk(0, 0, 7, 0));
        expect_at("reset_b", 1'b1, mk(0, 0, 7, 0));

        // Entry and first epochs: token fields {pkt,x,y}
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_at("entry", 1'b0, mk(1, 1, 7, 0));
        run(8, 1'b1); expect_at("ep1_pkt1", 1'b0, mk(1, 1, 7, 4'h4));
        run(8, 1'b1); expect_at("ep2_pkt2", 1'b0, mk(1, 1, 7, 4'h8));
        run(8, 1'b1); expect_at("ep3_pkt3", 1'b0, mk(1, 1, 7, 4'hC));
        run(8, 1'b1); expect_at("ep4_wrap_y1", 1'b0, mk(1, 1, 7, 4'h1));

        // Full period, then the return to zero
        run(88, 1'b1); expect_at("ep15_all_ones", 1'b0, mk(1, 1, 7, 4'hF));
        run(7, 1'b1);
        run(1, 1'b0);  expect_at("period_wrap", 1'b0, mk(1, 1, 7, 0));

        // Early advance at timer=5; off on the EARLY_ADV=0 instance
        run(2, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_at("early_adv", 1'b0, mk(1, 1, 7, 4'h4));
        expect_at("no_early_adv", 1'b1, mk(1, 0, 4, 0));
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_at("done_after_adv", 1'b0, mk(1, 1, 7, 4'h8));

        // golden_done coincident with timer=0: one advance only
        run(7, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_at("single_adv", 1'b0, mk(1, 1, 7, 4'hC));
        run(1, 1'b0);  expect_at("single_adv_next", 1'b0, mk(1, 0, 6, 4'hC));

        // Freeze at timer=3 for 10 cycles, golden_done ignored meanwhile
        run(3, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, (i == 4), 1'b0);
        expect_at("frozen", 1'b0, mk(1, 0, 3, 4'hC));
        run(1, 1'b0);  expect_at("release", 1'b0, mk(1, 0, 3, 4'hC));
        run(1, 1'b0);  expect_at("resume", 1'b0, mk(1, 0, 2, 4'hC));

        // Disable holds the token; reset clears it; re-enable restarts the epoch
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at("disable", 1'b0, mk(0, 0, 7, 4'hC));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_at("idle_done", 1'b0, mk(0, 0, 7, 4'hC));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at("reenable", 1'b0, mk(1, 1, 7, 4'hC));
        run(3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at("mid_reset", 1'b0, mk(0, 0, 7, 0));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at("post_reset_entry", 1'b0, mk(1, 1, 7, 0));
        run(2, 1'b0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        chk_int("drain", q.size(), 0);
        chk_int("visit_all", int'(seen), 16'hFFFF);
        chk_int("visit_dups", dups, 0);
        chk_int("visit_count", npulse, 16);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
